pwm_peripheral: RTL and testbench

- Consumes the five configuration bytes written over SPI (output enables, PWM-mode enables, duty cycle) and drives 16 output pins.
- Each pin is forced low, static high, or PWM-modulated from one shared 8-bit PWM timebase.
- Sits directly downstream of the SPI register block, in the system clock domain. The register bytes are treated as quasi-static, already synchronised configuration.

---
 rtl/pwm_peripheral.sv | 64 ++++++
 tb/tb_pwm_peripheral.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins low, static high or PWM from one shared 8-bit timebase
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, pins 7..0 (1 = enabled)
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   mode select, pins 7..0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  mode select, pins 15..8
//   pwm_duty_cycle   duty cycle, shadowed at each period boundary
//   out              registered pin drive
//   period_start     one-clk pulse on the first cycle of each PWM period (pwm_cnt = 0)
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  duty_shadow_q, duty_shadow_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q, period_start_d;
    logic [15:0] en_out, en_pwm;
    logic        step_tick, wrap, pwm;
    always_comb begin
        en_out         = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        step_tick      = presc_q == PRESC_LAST;
        presc_d        = step_tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d      = pwm_cnt_q + {7'd0, step_tick};
        // Duty is only ever loaded on the 255 -> 0 step, so a period never mixes two duties
        wrap           = step_tick && (pwm_cnt_q == 8'hFF);
        duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
        period_start_d = wrap;
        // 0xFF is forced full-on; the compare alone would drop out at cnt 255
        pwm            = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
        out_d          = en_out & (~en_pwm | {16{pwm}});
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= 16'd0;
            pwm_cnt_q      <= 8'd0;
            duty_shadow_q  <= 8'd0;
            out_q          <= 16'd0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end
    assign out          = out_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for pwm_peripheral (per-period high-time records)
module tb_pwm_peripheral;
    typedef struct packed {
        logic             chk;
        logic [11:0]      len;
        logic [15:0][11:0] hi;
    } rec_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
    logic [15:0] out1, out2;
    logic        ps1, ps2;
    int          tests = 0;
    int          fails = 0;
    rec_t        q[$];
    rec_t        mr;
    int          acc[16];
    int          len1, len2;
    bit          armed1, armed2;
    logic        prev_ps1, prev_ps2;
    always #5 clk = ~clk;
    pwm_peripheral #(.PRESCALE(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
        .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );
    pwm_peripheral #(.PRESCALE(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
        .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
        .pwm_duty_cycle(duty), .out(out2), .period_start(ps2)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    function automatic rec_t mk(input logic c, input logic [15:0] full, input logic [15:0] part,
                                input logic [11:0] h);
        rec_t r;
        r.chk = c;
        r.len = 12'd3328;
        for (int i = 0; i < 16; i++) r.hi[i] = full[i] ? 12'd3328 : (part[i] ? h : 12'd0);
        return r;
    endfunction
    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps1 && n < 4000);
        if (!ps1) begin
            tests++;
            fails++;
            $display("FAIL wait_ps: no period_start within %0d clks", n);
        end
    endtask
    // Each window runs from the cycle after one period_start through the next one,
    // matching the one-clk lag of the registered out behind pwm_cnt.
    always @(negedge clk) begin
        if (!rst_n) begin
            armed1 = 0;
            len1 = 0;
            prev_ps1 = 0;
            for (int i = 0; i < 16; i++) acc[i] = 0;
        end else begin
            len1++;
            for (int i = 0; i < 16; i++) acc[i] += int'(out1[i]);
            if (ps1) begin
                check("ps13_width", {31'd0, prev_ps1}, 0);
                if (armed1) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: period record with no expectation");
                    end else begin
                        mr = q.pop_front();
                        if (mr.chk) begin
                            check("period_len", len1, {20'd0, mr.len});
                            for (int i = 0; i < 16; i++)
                                check($sformatf("hi_bit%0d", i), acc[i], {20'd0, mr.hi[i]});
                        end
                    end
                end
                armed1 = 1;
                len1 = 0;
                for (int i = 0; i < 16; i++) acc[i] = 0;
            end
            prev_ps1 = ps1;
        end
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            armed2 = 0;
            len2 = 0;
            prev_ps2 = 0;
        end else begin
            len2++;
            if (ps2) begin
                check("ps1_width", {31'd0, prev_ps2}, 0);
                if (armed2) check("ps1_period", len2, 256);
                armed2 = 1;
                len2 = 0;
            end
            prev_ps2 = ps2;
        end
    end
    initial begin
        rst_n = 0;
        en_out_lo = 8'hFF; en_out_hi = 8'hFF; en_pwm_lo = 8'h00; en_pwm_hi = 8'h00; duty = 8'h00;
        #23;
        check("rst_out", out1, 0);
        check("rst_ps", ps1, 0);
        check("rst_out_p1", out2, 0);
        @(negedge clk);
        rst_n = 1;
        #1 check("rel_out_before_edge", out1, 0);
        @(negedge clk);
        check("rel_out_one_clk", out1, 16'hFFFF);
        repeat (5) @(negedge clk);
        check("pre_async_out", out1, 16'hFFFF);
        #2 rst_n = 0;
        #1 check("async_rst_out", out1, 0);
        check("async_rst_ps", ps1, 0);
        check("async_rst_out_p1", out2, 0);
        @(negedge clk);
        en_out_lo = 8'h01; en_out_hi = 8'h00; en_pwm_lo = 8'h01; en_pwm_hi = 8'h00; duty = 8'h80;
        @(negedge clk);
        rst_n = 1;
        wait_ps();
        q.push_back(mk(1, 16'h0000, 16'h0001, 12'd1664));
        duty = 8'h00;
        wait_ps();
        q.push_back(mk(1, 16'h0000, 16'h0001, 12'd0));
        duty = 8'hFF;
        wait_ps();
        q.push_back(mk(1, 16'h0001, 16'h0000, 12'd0));
        duty = 8'h01;
        wait_ps();
        q.push_back(mk(1, 16'h0000, 16'h0001, 12'd13));
        duty = 8'h40;
        wait_ps();
        en_out_lo = 8'hF0; en_out_hi = 8'h00; en_pwm_lo = 8'h30; en_pwm_hi = 8'h0F;
        q.push_back(mk(1, 16'h00C0, 16'h0030, 12'd832));
        duty = 8'h20;
        wait_ps();
        q.push_back(mk(1, 16'h00C0, 16'h0030, 12'd416));
        repeat (208) @(negedge clk);
        duty = 8'hC0;
        wait_ps();
        q.push_back(mk(1, 16'h00C0, 16'h0030, 12'd2496));
        wait_ps();
        q.push_back(mk(0, 16'h0000, 16'h0000, 12'd0));
        repeat (100) @(negedge clk);
        en_out_hi = 8'h80;
        #1 check("en15_a_before_edge", {31'd0, out1[15]}, 0);
        @(negedge clk);
        check("en15_a_one_clk", {31'd0, out1[15]}, 1);
        en_out_hi = 8'h00;
        @(negedge clk);
        check("en15_a_off", {31'd0, out1[15]}, 0);
        repeat (1337) @(negedge clk);
        en_out_hi = 8'h80;
        #1 check("en15_b_before_edge", {31'd0, out1[15]}, 0);
        @(negedge clk);
        check("en15_b_one_clk", {31'd0, out1[15]}, 1);
        en_out_hi = 8'h00;
        wait_ps();
        @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
